// File: rtl/pipeline_ctrl.sv
// Packet pipeline sequencer: parser -> matcher -> executor handshakes, shared
// byte-wide memory port multiplexing, and between-packet matcher reconfiguration.
module pipeline_ctrl #(
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid_i,
    output logic                  pkt_done_o,
    output logic                  pkt_hit_o,
    output logic                  pkt_err_o,
    output logic                  prs_start_o,
    input  logic                  prs_ready_i,
    output logic                  mt_start_o,
    input  logic                  mt_ready_i,
    input  logic [ADDR_WIDTH-1:0] mt_val_addr_i,
    output logic                  ex_start_o,
    input  logic                  ex_ready_i,
    output logic [ADDR_WIDTH-1:0] ex_val_addr_o,
    input  logic                  prs_mem_ce_i,
    input  logic                  prs_mem_we_i,
    input  logic [ADDR_WIDTH-1:0] prs_mem_addr_i,
    input  logic [3:0]            prs_mem_width_i,
    input  logic [DATA_WIDTH-1:0] prs_mem_data_i,
    output logic [DATA_WIDTH-1:0] prs_mem_data_o,
    input  logic                  mt_mem_ce_i,
    input  logic                  mt_mem_we_i,
    input  logic [ADDR_WIDTH-1:0] mt_mem_addr_i,
    input  logic [3:0]            mt_mem_width_i,
    input  logic [DATA_WIDTH-1:0] mt_mem_data_i,
    output logic [DATA_WIDTH-1:0] mt_mem_data_o,
    input  logic                  ex_mem_ce_i,
    input  logic                  ex_mem_we_i,
    input  logic [ADDR_WIDTH-1:0] ex_mem_addr_i,
    input  logic [3:0]            ex_mem_width_i,
    input  logic [DATA_WIDTH-1:0] ex_mem_data_i,
    output logic [DATA_WIDTH-1:0] ex_mem_data_o,
    output logic                  mem_ce_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [3:0]            mem_width_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  cfg_req_i,
    input  logic [3:0]            cfg_hdr_id_i,
    input  logic [5:0]            cfg_key_off_i,
    input  logic [5:0]            cfg_key_len_i,
    output logic                  cfg_ack_o,
    output logic                  mod_start_o,
    output logic [3:0]            mod_match_hdr_id_o,
    output logic [5:0]            mod_match_key_off_o,
    output logic [5:0]            mod_match_key_len_o,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o
);

    localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [3:0] {
        IDLE, CFG, PRS_ISSUE, PRS_WAIT, MT_ISSUE, MT_WAIT, EX_ISSUE, EX_WAIT, DONE
    } state_t;

    state_t             state_q, state_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               hit_d, err_d, latch_addr;
    logic               tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

    // Next-state logic; ISSUE ignores ready since it may be stale from the last packet
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        hit_d      = 1'b0;
        err_d      = 1'b0;
        latch_addr = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_req_i)        state_d = CFG;
                else if (pkt_valid_i) state_d = PRS_ISSUE;
            end
            CFG:       state_d = IDLE;
            PRS_ISSUE: begin tmo_d = '0; state_d = PRS_WAIT; end
            PRS_WAIT: begin
                if (prs_ready_i)  state_d = MT_ISSUE;
                else if (tmo_hit) begin state_d = DONE; err_d = 1'b1; end
                else              tmo_d = tmo_q + TMO_W'(1);
            end
            MT_ISSUE:  begin tmo_d = '0; state_d = MT_WAIT; end
            MT_WAIT: begin
                if (mt_ready_i) begin
                    latch_addr = 1'b1;
                    state_d    = (mt_val_addr_i != '0) ? EX_ISSUE : DONE;
                end else if (tmo_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            EX_ISSUE:  begin tmo_d = '0; state_d = EX_WAIT; end
            EX_WAIT: begin
                if (ex_ready_i)   begin state_d = DONE; hit_d = 1'b1; end
                else if (tmo_hit) begin state_d = DONE; err_d = 1'b1; end
                else              tmo_d = tmo_q + TMO_W'(1);
            end
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // State, handshake outputs and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= IDLE;
            tmo_q               <= '0;
            prs_start_o         <= 1'b0;
            mt_start_o          <= 1'b0;
            ex_start_o          <= 1'b0;
            pkt_done_o          <= 1'b0;
            pkt_hit_o           <= 1'b0;
            pkt_err_o           <= 1'b0;
            cfg_ack_o           <= 1'b0;
            mod_start_o         <= 1'b0;
            ex_val_addr_o       <= '0;
            mod_match_hdr_id_o  <= '0;
            mod_match_key_off_o <= '0;
            mod_match_key_len_o <= '0;
            pkt_cnt_o           <= '0;
            hit_cnt_o           <= '0;
            err_cnt_o           <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            prs_start_o <= (state_d == PRS_ISSUE) || (state_d == PRS_WAIT);
            mt_start_o  <= (state_d == MT_ISSUE)  || (state_d == MT_WAIT);
            ex_start_o  <= (state_d == EX_ISSUE)  || (state_d == EX_WAIT);
            pkt_done_o  <= (state_d == DONE);
            pkt_hit_o   <= hit_d;
            pkt_err_o   <= err_d;
            cfg_ack_o   <= (state_d == CFG);
            mod_start_o <= (state_d == CFG);
            if (latch_addr) ex_val_addr_o <= mt_val_addr_i;
            if (state_d == CFG) begin
                mod_match_hdr_id_o  <= cfg_hdr_id_i;
                mod_match_key_off_o <= cfg_key_off_i;
                mod_match_key_len_o <= cfg_key_len_i;
            end
            if (state_q == DONE) begin
                pkt_cnt_o <= pkt_cnt_o + CNT_WIDTH'(1);
                if (pkt_hit_o) hit_cnt_o <= hit_cnt_o + CNT_WIDTH'(1);
                if (pkt_err_o) err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

    // Memory port owned by whichever stage the registered state selects
    always_comb begin
        mem_ce_o       = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_width_o    = '0;
        mem_data_o     = '0;
        prs_mem_data_o = '0;
        mt_mem_data_o  = '0;
        ex_mem_data_o  = '0;
        case (state_q)
            PRS_ISSUE, PRS_WAIT: begin
                mem_ce_o       = prs_mem_ce_i;
                mem_we_o       = prs_mem_we_i;
                mem_addr_o     = prs_mem_addr_i;
                mem_width_o    = prs_mem_width_i;
                mem_data_o     = prs_mem_data_i;
                prs_mem_data_o = mem_data_i;
            end
            MT_ISSUE, MT_WAIT: begin
                mem_ce_o      = mt_mem_ce_i;
                mem_we_o      = mt_mem_we_i;
                mem_addr_o    = mt_mem_addr_i;
                mem_width_o   = mt_mem_width_i;
                mem_data_o    = mt_mem_data_i;
                mt_mem_data_o = mem_data_i;
            end
            EX_ISSUE, EX_WAIT: begin
                mem_ce_o      = ex_mem_ce_i;
                mem_we_o      = ex_mem_we_i;
                mem_addr_o    = ex_mem_addr_i;
                mem_width_o   = ex_mem_width_i;
                mem_data_o    = ex_mem_data_i;
                ex_mem_data_o = mem_data_i;
            end
            default: ;
        endcase
    end

endmodule
